// File: rtl/nibble_serial_sub32_pkg.sv
// Shared definitions for the nibble-serial subtractor: default widths,
// derived digit count, counter width and FSM state encoding.
package sub32_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIGIT_DEF = 4;
  localparam int N_DEF     = WIDTH_DEF / DIGIT_DEF;
  localparam int CNT_W     = $clog2(N_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_sub32_sub4_bla.sv
// sub4_bla: DIGIT-bit borrow-lookahead subtract slice, d = a - b - bin.
// Every internal borrow is expanded as a flat generate/propagate sum of
// products, so no borrow ripples from bit to bit.
module sub4_bla #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] p;
  logic [DIGIT:0]   bw;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Lookahead borrow i+1 = g[i] | p[i]g[i-1] | ... | p[i..0]bin
  always_comb begin
    logic prop;
    logic acc;
    bw    = '0;
    bw[0] = bin;
    prop  = 1'b1;
    acc   = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      prop = 1'b1;
      acc  = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      bw[i+1] = acc | (prop & bin);
    end
  end

  assign d    = a ^ b ^ bw[DIGIT-1:0];
  assign bout = bw[DIGIT];

endmodule

// File: rtl/nibble_serial_sub32.sv
// nibble_serial_sub32: multi-cycle subtractor, one DIGIT-bit digit per cycle
// through a borrow-lookahead slice, LSB digit first, valid/ready on both sides.
// Optional macro ADDSUB_MODE_EN adds an 'op' input (1 = add) latched at accept.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | one digit per cycle through the slice, N cycles
// DONE  | result held until out_ready
module nibble_serial_sub32
  import sub32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
`ifdef ADDSUB_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic             accept;
  logic             op_in;
  logic             mode_add;
  logic [DIGIT-1:0] s_b;
  logic [DIGIT-1:0] s_d;
  logic             s_bout;
  logic [WIDTH-1:0] diff_nx;
  logic             ovf_nx;

`ifdef ADDSUB_MODE_EN
  logic op_q;

  // Operation mode is captured with the operands
  always_ff @(posedge clk) begin
    if (rst)
      op_q <= 1'b0;
    else if (accept)
      op_q <= op;
  end

  assign op_in    = op;
  assign mode_add = op_q;
`else
  assign op_in    = 1'b0;
  assign mode_add = 1'b0;
`endif

  // Add mode reuses the subtract slice: a + b + c == a - ~b - ~c,
  // and carry out is the inverse of the final borrow.
  assign s_b = mode_add ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];

  sub4_bla #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sh[DIGIT-1:0]),
    .b    (s_b),
    .bin  (brw),
    .d    (s_d),
    .bout (s_bout)
  );

  assign diff_nx = {s_d, diff[WIDTH-1:DIGIT]};
  assign ovf_nx  = mode_add ? ((a_msb == b_msb) & (s_d[DIGIT-1] != a_msb))
                            : ((a_msb != b_msb) & (s_d[DIGIT-1] != a_msb));
  assign accept  = (state == IDLE) & in_valid & ~rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (accept)
          state_nx = RUN;
      end
      RUN: begin
        if (cnt == LAST)
          state_nx = DONE;
      end
      DONE: begin
        out_valid = ~rst;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand shifters, digit counter, result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      brw   <= borrow_in ^ op_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      brw  <= s_bout;
      cnt  <= cnt + 1'b1;
      diff <= diff_nx;
      if (cnt == LAST) begin
        borrow_out <= s_bout ^ mode_add;
        zero       <= (diff_nx == '0);
        overflow   <= ovf_nx;
      end
    end
  end

endmodule
